pipe_mux: RTL and testbench

PIPE_MUX -- requirements
Module: pipe_mux

---
 rtl/pipe_mux.sv | 88 ++++++++
 tb/tb_pipe_mux.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux.sv
// Registered N-to-1 multiplexer with a 1- or 2-stage valid pipeline, stall/flush
// control, out-of-range select substitution and a saturating select-error counter.
module pipe_mux #(
    parameter int unsigned WIDTH                = 32,
    parameter int unsigned NUM_IN               = 4,
    parameter int unsigned SEL_W                = $clog2(NUM_IN),
    parameter int unsigned STAGES               = 1,
    parameter logic [WIDTH-1:0] DEFAULT_VAL     = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN*WIDTH-1:0]   d_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      in_valid,
    input  logic                      stall,
    input  logic                      flush,
    output logic [WIDTH-1:0]          y,
    output logic                      out_valid,
    output logic                      sel_err,
    output logic [7:0]                err_cnt
);

    localparam int unsigned LAST = STAGES - 1;
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    logic [WIDTH-1:0] data_q  [STAGES];
    logic             valid_q [STAGES];
    logic             err_q   [STAGES];

    logic [WIDTH-1:0] sel_data;
    logic             sel_oor;
    logic             accept;

    // A select at or beyond NUM_IN picks DEFAULT_VAL; with a power-of-two
    // NUM_IN the compare can never be true.
    always_comb begin
        sel_oor  = ({1'b0, sel} >= NUM_IN_W);
        sel_data = DEFAULT_VAL;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = d_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = in_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
                err_q[i]   <= 1'b0;
            end
            err_cnt <= '0;
        end else begin
            if (accept && sel_oor && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            // Flush only kills valid/err; data registers keep their contents.
            if (flush) begin
                for (int unsigned i = 0; i < STAGES; i++) begin
                    valid_q[i] <= 1'b0;
                    err_q[i]   <= 1'b0;
                end
            end else if (!stall) begin
                valid_q[0] <= in_valid;
                err_q[0]   <= in_valid && sel_oor;
                if (in_valid) begin
                    data_q[0] <= sel_data;
                end
                for (int unsigned i = 1; i < STAGES; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    err_q[i]   <= err_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end
    end

    assign y         = data_q[LAST];
    assign out_valid = valid_q[LAST];
    assign sel_err   = err_q[LAST];

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: two configurations share one stimulus stream and are compared
// each edge against a queue-based in-flight transfer model.
module tb_pipe_mux;

    logic         clk;
    logic         rst_n;
    logic [159:0] d_in;
    logic [2:0]   sel;
    logic         in_valid;
    logic         stall;
    logic         flush;

    logic [31:0]  y_a, y_b;
    logic         ov_a, ov_b, se_a, se_b;
    logic [7:0]   ec_a, ec_b;

    int checks = 0;
    int errors = 0;

    pipe_mux #(.WIDTH(32), .NUM_IN(4), .STAGES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .d_in(d_in[127:0]), .sel(sel[1:0]),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .y(y_a), .out_valid(ov_a), .sel_err(se_a), .err_cnt(ec_a)
    );

    pipe_mux #(.WIDTH(32), .NUM_IN(5), .STAGES(2), .DEFAULT_VAL(32'hFFFF0000)) dut_b (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .y(y_b), .out_valid(ov_b), .sel_err(se_b), .err_cnt(ec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: each accepted transfer waits STAGES unstalled edges to reach y.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          left;
    } item_t;

    item_t       fifo [2][4];
    int          cnt  [2];
    logic [31:0] m_y  [2];
    logic        m_ov [2];
    logic        m_se [2];
    int          m_cnt[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; m_y[d] = '0; m_ov[d] = 1'b0; m_se[d] = 1'b0; m_cnt[d] = 0;
        end
    endtask

    task automatic model_edge();
        logic [2:0]  s;
        int          num, stg;
        logic        oor;
        logic [31:0] v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            num = (d == 0) ? 4 : 5;
            stg = (d == 0) ? 1 : 2;
            s   = (d == 0) ? {1'b0, sel[1:0]} : sel;
            oor = (int'(s) >= num);
            v   = oor ? 32'hFFFF0000 : d_in[int'(s)*32 +: 32];
            if (in_valid && !stall && !flush && oor && m_cnt[d] < 255) m_cnt[d]++;
            if (flush) begin
                cnt[d] = 0; m_ov[d] = 1'b0; m_se[d] = 1'b0;
            end else if (!stall) begin
                for (int i = 0; i < cnt[d]; i++) fifo[d][i].left--;
                if (in_valid) begin
                    fifo[d][cnt[d]] = '{data: v, err: oor, left: stg - 1};
                    cnt[d]++;
                end
                if (cnt[d] > 0 && fifo[d][0].left == 0) begin
                    m_y[d]  = fifo[d][0].data;
                    m_ov[d] = 1'b1;
                    m_se[d] = fifo[d][0].err;
                    for (int i = 1; i < cnt[d]; i++) fifo[d][i-1] = fifo[d][i];
                    cnt[d]--;
                end else begin
                    m_ov[d] = 1'b0; m_se[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a.y",         y_a,  m_y[0]);
        chk("a.out_valid", {31'b0, ov_a}, {31'b0, m_ov[0]});
        chk("a.sel_err",   {31'b0, se_a}, {31'b0, m_se[0]});
        chk("a.err_cnt",   {24'b0, ec_a}, 32'(m_cnt[0]));
        chk("b.y",         y_b,  m_y[1]);
        chk("b.out_valid", {31'b0, ov_b}, {31'b0, m_ov[1]});
        chk("b.sel_err",   {31'b0, se_b}, {31'b0, m_se[1]});
        chk("b.err_cnt",   {24'b0, ec_b}, 32'(m_cnt[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic st, input logic fl);
        in_valid = v; sel = s; stall = st; flush = fl;
    endtask

    task automatic rand_data();
        for (int k = 0; k < 5; k++) d_in[k*32 +: 32] = $urandom;
    endtask

    logic [31:0] got [$];
    int          saved_cnt;

    initial begin
        rst_n = 1'b0;
        d_in  = '0;
        drive(0, 0, 0, 0);
        model_reset();
        #3;
        check_all();
        step();
        #2 rst_n = 1'b1;

        // Basic select on the 4-input single-stage mux
        rand_data();
        d_in[2*32 +: 32] = 32'hDEADBEEF;
        drive(1, 3'd2, 0, 0);
        step();
        chk("req031.y", y_a, 32'hDEADBEEF);
        chk("req031.ov", {31'b0, ov_a}, 32'd1);
        chk("req031.se", {31'b0, se_a}, 32'd0);

        // Out-of-range select on the 5-input mux, three accepted
        drive(1, 3'd7, 0, 0);
        step(); step(); step();
        chk("req032.cnt3", {24'b0, ec_b}, 32'd3);
        chk("req032.y",    y_b, 32'hFFFF0000);
        chk("req032.se",   {31'b0, se_b}, 32'd1);
        chk("req032.ov",   {31'b0, ov_b}, 32'd1);

        // Randomized traffic with stalls and flushes
        for (int n = 0; n < 300; n++) begin
            rand_data();
            drive(($urandom_range(3) != 0), 3'($urandom_range(7)),
                  ($urandom_range(6) == 0), ($urandom_range(19) == 0));
            step();
        end

        // Drain, then A,B,C with a two-cycle stall after B
        drive(0, 0, 0, 1); step();
        drive(0, 0, 0, 0); step(); step();
        got.delete();
        d_in[1*32 +: 32] = 32'hAAAA0001; drive(1, 3'd1, 0, 0); step();
        if (ov_b) got.push_back(y_b);
        d_in[2*32 +: 32] = 32'hBBBB0002; drive(1, 3'd2, 0, 0); step();
        if (ov_b) got.push_back(y_b);
        d_in[3*32 +: 32] = 32'hCCCC0003; drive(1, 3'd3, 1, 0); step();
        chk("req033.hold1", y_b, 32'hAAAA0001);
        step();
        chk("req033.hold2", y_b, 32'hAAAA0001);
        chk("req033.holdov", {31'b0, ov_b}, 32'd1);
        drive(1, 3'd3, 0, 0); step();
        if (ov_b) got.push_back(y_b);
        drive(0, 0, 0, 0); step();
        if (ov_b) got.push_back(y_b);
        step();
        if (ov_b) got.push_back(y_b);
        chk("req033.count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("req033.first",  got[0], 32'hAAAA0001);
            chk("req033.second", got[1], 32'hBBBB0002);
            chk("req033.third",  got[2], 32'hCCCC0003);
        end

        // Flush together with stall while two transfers are in flight
        d_in[0 +: 32] = 32'h11110000; drive(1, 3'd0, 0, 0); step();
        d_in[0 +: 32] = 32'h22220000; drive(1, 3'd7, 0, 0); step();
        saved_cnt = m_cnt[1];
        chk("req034.pre", y_b, 32'h11110000);
        drive(1, 3'd7, 1, 1); step();
        chk("req034.ov",  {31'b0, ov_b}, 32'd0);
        chk("req034.se",  {31'b0, se_b}, 32'd0);
        chk("req034.y",   y_b, 32'h11110000);
        chk("req034.cnt", {24'b0, ec_b}, 32'(saved_cnt));
        drive(0, 0, 0, 0); step(); step();

        // Saturation of the error counter
        for (int n = 0; n < 300; n++) begin
            rand_data();
            drive(1, 3'd7, 0, 0);
            step();
        end
        chk("req032.sat", {24'b0, ec_b}, 32'd255);
        chk("req028.cnt", {24'b0, ec_a}, 32'd0);

        // Asynchronous reset between edges while outputs are valid
        rand_data();
        drive(1, 3'd1, 0, 0); step(); step();
        chk("req035.pre", {31'b0, ov_b}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("req035.y",   y_b, 32'd0);
        chk("req035.cnt", {24'b0, ec_b}, 32'd0);
        #1 rst_n = 1'b1;
        d_in[1*32 +: 32] = 32'h5A5A1234;
        drive(1, 3'd1, 0, 0); step();
        chk("req035.a1", y_a, 32'h5A5A1234);
        chk("req035.b1ov", {31'b0, ov_b}, 32'd0);
        drive(0, 0, 0, 0); step();
        chk("req035.b2", y_b, 32'h5A5A1234);
        chk("req035.b2ov", {31'b0, ov_b}, 32'd1);

        // More random traffic after reset
        for (int n = 0; n < 100; n++) begin
            rand_data();
            drive(($urandom_range(3) != 0), 3'($urandom_range(7)),
                  ($urandom_range(5) == 0), ($urandom_range(15) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
